// File: rtl/ledger_access_arbiter.sv
// Round-robin arbiter owning the account balance store.
// Each granted transaction runs load, exec and commit as one atomic sequence.
module ledger_access_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int REQ_W    = 2,
   parameter int NUM_ACCT = 10,
   parameter int IDX_W    = 4,
   parameter int BAL_W    = 8,
   parameter int INIT_BAL = 100
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [2*NUM_REQ-1:0]     op,
   input  logic [IDX_W*NUM_REQ-1:0] src_index,
   input  logic [IDX_W*NUM_REQ-1:0] dst_index,
   input  logic [BAL_W*NUM_REQ-1:0] amount,
   output logic [NUM_REQ-1:0]       ack,
   output logic [REQ_W-1:0]         grant_id,
   output logic                     busy,
   output logic [BAL_W-1:0]         resp_balance,
   output logic                     err_balance,
   output logic                     err_index
);

   localparam logic [IDX_W-1:0] ACCT_LIM = IDX_W'(NUM_ACCT);
   localparam logic [BAL_W-1:0] INIT_V   = BAL_W'(INIT_BAL);
   localparam logic [1:0]       OP_READ  = 2'b00;
   localparam logic [1:0]       OP_WDR   = 2'b01;
   localparam logic [1:0]       OP_DEP   = 2'b10;
   localparam logic [1:0]       OP_XFER  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXEC,
      COMMIT
   } state_t;

   state_t            state;
   logic [REQ_W-1:0]  ptr;
   logic [BAL_W-1:0]  bal [NUM_ACCT];

   logic [1:0]        lat_op;
   logic [IDX_W-1:0]  lat_src;
   logic [IDX_W-1:0]  lat_dst;
   logic [BAL_W-1:0]  lat_amt;
   logic [BAL_W-1:0]  src_bal;
   logic [BAL_W-1:0]  dst_bal;
   logic              idx_err;
   logic [BAL_W-1:0]  new_src;
   logic [BAL_W-1:0]  new_dst;
   logic              wr_src;
   logic              wr_dst;

   logic              found;
   logic [REQ_W-1:0]  pick;
   logic [REQ_W-1:0]  cand;
   int                sel;

   // First requesting port at or after the pointer, wrapping upward.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ptr + REQ_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      sel = int'(pick);
   end

   logic              src_bad;
   logic              dst_bad;

   always_comb begin
      src_bad = lat_src >= ACCT_LIM;
      dst_bad = lat_dst >= ACCT_LIM;
   end

   logic [BAL_W:0]    src_sum;
   logic [BAL_W:0]    dst_sum;
   logic              short_funds;
   logic [BAL_W-1:0]  x_new_src;
   logic [BAL_W-1:0]  x_new_dst;
   logic              x_err_bal;
   logic              x_wr_src;
   logic              x_wr_dst;

   // Result computation with one carry bit to catch overflow.
   always_comb begin
      src_sum     = {1'b0, src_bal} + {1'b0, lat_amt};
      dst_sum     = {1'b0, dst_bal} + {1'b0, lat_amt};
      short_funds = lat_amt > src_bal;
      x_new_src   = src_bal;
      x_new_dst   = dst_bal;
      x_err_bal   = 1'b0;
      x_wr_src    = 1'b0;
      x_wr_dst    = 1'b0;
      case (lat_op)
         OP_WDR: begin
            if (short_funds) begin
               x_err_bal = 1'b1;
            end else begin
               x_new_src = src_bal - lat_amt;
               x_wr_src  = 1'b1;
            end
         end
         OP_DEP: begin
            if (src_sum[BAL_W]) begin
               x_err_bal = 1'b1;
            end else begin
               x_new_src = src_sum[BAL_W-1:0];
               x_wr_src  = 1'b1;
            end
         end
         OP_XFER: begin
            if (lat_src == lat_dst) begin
               x_err_bal = 1'b0;
            end else if (short_funds || dst_sum[BAL_W]) begin
               x_err_bal = 1'b1;
            end else begin
               x_new_src = src_bal - lat_amt;
               x_new_dst = dst_sum[BAL_W-1:0];
               x_wr_src  = 1'b1;
               x_wr_dst  = 1'b1;
            end
         end
         default: begin
            x_err_bal = 1'b0;
         end
      endcase
      if (idx_err) begin
         x_new_src = src_bal;
         x_new_dst = dst_bal;
         x_err_bal = 1'b0;
         x_wr_src  = 1'b0;
         x_wr_dst  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         grant_id     <= '0;
         busy         <= 1'b0;
         ack          <= '0;
         resp_balance <= '0;
         err_balance  <= 1'b0;
         err_index    <= 1'b0;
         lat_op       <= OP_READ;
         lat_src      <= '0;
         lat_dst      <= '0;
         lat_amt      <= '0;
         src_bal      <= '0;
         dst_bal      <= '0;
         idx_err      <= 1'b0;
         new_src      <= '0;
         new_dst      <= '0;
         wr_src       <= 1'b0;
         wr_dst       <= 1'b0;
         for (int a = 0; a < NUM_ACCT; a++) begin
            bal[a] <= INIT_V;
         end
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= pick;
                  lat_op   <= op[sel*2 +: 2];
                  lat_src  <= src_index[sel*IDX_W +: IDX_W];
                  lat_dst  <= dst_index[sel*IDX_W +: IDX_W];
                  lat_amt  <= amount[sel*BAL_W +: BAL_W];
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               idx_err <= src_bad || (lat_op == OP_XFER && dst_bad);
               src_bal <= src_bad ? '0 : bal[lat_src];
               dst_bal <= dst_bad ? '0 : bal[lat_dst];
               state   <= EXEC;
            end
            EXEC: begin
               new_src      <= x_new_src;
               new_dst      <= x_new_dst;
               wr_src       <= x_wr_src;
               wr_dst       <= x_wr_dst;
               ack          <= NUM_REQ'(1) << grant_id;
               resp_balance <= x_new_src;
               err_balance  <= x_err_bal;
               err_index    <= idx_err;
               state        <= COMMIT;
            end
            COMMIT: begin
               // Source and destination land on the same edge.
               if (wr_src) bal[lat_src] <= new_src;
               if (wr_dst) bal[lat_dst] <= new_dst;
               wr_src <= 1'b0;
               wr_dst <= 1'b0;
               ptr    <= grant_id + REQ_W'(1);
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ledger_access_arbiter.sv
// Bench for ledger_access_arbiter: directed vector table, round-robin
// schedule checks, async reset abort and randomized model comparison.
module tb_ledger_access_arbiter;

   localparam int NR = 4;
   localparam int IW = 4;
   localparam int BW = 8;
   localparam int NA = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    req = '0;
   logic [7:0]    op = '0;
   logic [15:0]   src = '0;
   logic [15:0]   dst = '0;
   logic [31:0]   amt = '0;
   logic [3:0]    ack;
   logic [1:0]    grant_id;
   logic          busy;
   logic [7:0]    resp;
   logic          eb;
   logic          ei;

   ledger_access_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .op           (op),
      .src_index    (src),
      .dst_index    (dst),
      .amount       (amt),
      .ack          (ack),
      .grant_id     (grant_id),
      .busy         (busy),
      .resp_balance (resp),
      .err_balance  (eb),
      .err_index    (ei)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int mbal[NA];
   int rr_ptr = 0;

   typedef struct {
      int id;
      int o;
      int s;
      int d;
      int a;
      int resp;
      int eb;
      int ei;
   } vec_t;

   vec_t tab[14];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the next idle negedge.
   task automatic do_txn(input int id, input int o, input int s,
                         input int d, input int a, input int er,
                         input int eeb, input int eei);
      bit got;
      int k;
      op[2*id +: 2]    = 2'(o);
      src[IW*id +: IW] = 4'(s);
      dst[IW*id +: IW] = 4'(d);
      amt[BW*id +: BW] = 8'(a);
      req[id]          = 1'b1;
      got = 1'b0;
      k   = 0;
      while (!got && k < 12) begin
         @(negedge clk);
         k++;
         if (k <= 3) begin
            chk("busy", int'(busy), 1);
            chk("grant", int'(grant_id), id);
         end
         if (ack != 0) begin
            got = 1'b1;
            chk("latency", k, 3);
         end
      end
      if (!got) begin
         chk("ack_timeout", 0, 1);
      end else begin
         chk("ack_onehot", int'(ack), 1 << id);
         if (er >= 0) chk("resp", int'(resp), er);
         chk("err_balance", int'(eb), eeb);
         chk("err_index", int'(ei), eei);
      end
      req[id] = 1'b0;
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_ack", int'(ack), 0);
   endtask

   // Expected grant order comes from a plain pending-set search.
   task automatic sched(input logic [3:0] mask, input bit from_reset);
      logic [3:0] pend;
      int         e;
      pend = mask;
      op   = '0;
      src  = '0;
      req  = mask;
      if (from_reset) rst = 1'b0;
      while (pend != 0) begin
         e = -1;
         for (int i = 0; i < NR; i++) begin
            if (e < 0 && pend[(rr_ptr + i) % NR]) e = (rr_ptr + i) % NR;
         end
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("sched_busy", int'(busy), 1);
            chk("sched_grant", int'(grant_id), e);
            chk("sched_ack", int'(ack), (c == 3) ? (1 << e) : 0);
         end
         req[e]  = 1'b0;
         pend[e] = 1'b0;
         rr_ptr  = (e + 1) % NR;
         @(negedge clk);
         chk("sched_idle", int'(busy), 0);
      end
   endtask

   task automatic model(input int o, input int s, input int d, input int a,
                        output int r, output int xeb, output int xei);
      xei = (s >= NA || (o == 3 && d >= NA)) ? 1 : 0;
      xeb = 0;
      r   = -1;
      if (xei == 0) begin
         case (o)
            1: if (a > mbal[s]) xeb = 1; else mbal[s] -= a;
            2: if (mbal[s] + a > 255) xeb = 1; else mbal[s] += a;
            3: begin
               if (s != d) begin
                  if (a > mbal[s] || mbal[d] + a > 255) xeb = 1;
                  else begin
                     mbal[s] -= a;
                     mbal[d] += a;
                  end
               end
            end
            default: xeb = 0;
         endcase
      end
      if (s < NA) r = mbal[s];
   endtask

   initial begin
      int r;
      int xeb;
      int xei;
      int o;
      int s;
      int d;
      int a;
      int id;

      tab[0]  = '{0, 0, 3, 0, 0, 100, 0, 0};
      tab[1]  = '{1, 1, 2, 0, 30, 70, 0, 0};
      tab[2]  = '{1, 1, 2, 0, 80, 70, 1, 0};
      tab[3]  = '{1, 0, 2, 0, 0, 70, 0, 0};
      tab[4]  = '{2, 3, 1, 5, 40, 60, 0, 0};
      tab[5]  = '{2, 0, 5, 0, 0, 140, 0, 0};
      tab[6]  = '{2, 2, 5, 0, 200, 140, 1, 0};
      tab[7]  = '{2, 0, 5, 0, 0, 140, 0, 0};
      tab[8]  = '{1, 1, 12, 0, 5, -1, 0, 1};
      tab[9]  = '{3, 3, 3, 10, 150, 100, 0, 1};
      tab[10] = '{0, 0, 3, 0, 0, 100, 0, 0};
      tab[11] = '{0, 0, 2, 0, 0, 70, 0, 0};
      tab[12] = '{3, 3, 4, 4, 250, 100, 0, 0};
      tab[13] = '{3, 2, 9, 0, 155, 255, 0, 0};

      rst = 1'b1;
      req = 4'b1111;
      repeat (2) @(negedge clk);
      chk("rst_ack", int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant", int'(grant_id), 0);
      chk("rst_resp", int'(resp), 0);
      chk("rst_eb", int'(eb), 0);
      chk("rst_ei", int'(ei), 0);

      rr_ptr = 0;
      sched(4'b1111, 1'b1);
      sched(4'b1001, 1'b0);

      foreach (tab[i]) begin
         do_txn(tab[i].id, tab[i].o, tab[i].s, tab[i].d, tab[i].a,
                tab[i].resp, tab[i].eb, tab[i].ei);
      end

      // Reset lands mid-EXEC of a transfer: nothing may commit.
      op[3:2]  = 2'd3;
      src[7:4] = 4'd1;
      dst[7:4] = 4'd5;
      amt[15:8] = 8'd40;
      req[1]   = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_abort_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_resp", int'(resp), 0);
      chk("abort_ack", int'(ack), 0);
      chk("abort_grant", int'(grant_id), 0);
      req = '0;
      @(negedge clk);
      chk("abort_noack", int'(ack), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_noack2", int'(ack), 0);
      do_txn(0, 0, 1, 0, 0, 100, 0, 0);
      do_txn(0, 0, 5, 0, 0, 100, 0, 0);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      foreach (mbal[i]) mbal[i] = 100;
      for (int n = 0; n < 150; n++) begin
         id = int'($urandom_range(0, 3));
         o  = int'($urandom_range(0, 3));
         s  = int'($urandom_range(0, 11));
         d  = int'($urandom_range(0, 11));
         a  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 60));
         model(o, s, d, a, r, xeb, xei);
         do_txn(id, o, s, d, a, r, xeb, xei);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
